multicycle_ctrl: RTL and testbench

- Moore-style main controller FSM for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
- Sequences the shared datapath: one memory port, one ALU, instruction register, PC.
- Replaces the single-cycle main decoder in the multicycle build. Sits beside the existing ALU decoder, which consumes ALUOp.
- Adds a memory-ready handshake so fetch and data accesses stall on slow memory.

---
 rtl/multicycle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main controller FSM for the multicycle RV32I core, with memory-ready stalls.
// Optional illegal-opcode trap state: define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         ALUOp,
    output logic               RegWrite,
    output logic               Illegal,
    output logic [STATE_W-1:0] dbg_state
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMREAD  = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWRITE = STATE_W'(5),
        S_EXECR    = STATE_W'(6),
        S_EXECI    = STATE_W'(7),
        S_ALUWB    = STATE_W'(8),
        S_BEQ      = STATE_W'(9),
        S_JAL      = STATE_W'(10)
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        ,
        S_TRAP     = STATE_W'(11)
`endif
    } state_e;

    // Per-state control word; fetch marks the MemReady-gated IR/PC load.
    typedef struct packed {
        logic       fetch;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       pc_update;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctl_t;

    state_e state_q, state_d;
    ctl_t   ctl_q;

    function automatic ctl_t decode(input state_e s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch      = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                c.illegal = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctl_q   <= decode(S_FETCH);
        end else begin
            state_q <= state_d;
            ctl_q   <= decode(state_d);
        end
    end

    always_comb begin
        if (reset) begin
            AdrSrc    = 1'b0;
            ResultSrc = 2'b10;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b10;
            ALUOp     = 2'b00;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
        end else begin
            AdrSrc    = ctl_q.adr_src;
            ResultSrc = ctl_q.result_src;
            ALUSrcA   = ctl_q.alu_src_a;
            ALUSrcB   = ctl_q.alu_src_b;
            ALUOp     = ctl_q.alu_op;
            MemWrite  = ctl_q.mem_write;
            RegWrite  = ctl_q.reg_write;
            IRWrite   = ctl_q.fetch & MemReady;
            PCWrite   = ctl_q.pc_update
                      | (ctl_q.fetch & MemReady)
                      | (ctl_q.branch & Zero);
        end
    end

    always_comb begin
        case (op)
            OP_LW, OP_I: ImmSrc = 2'b00;
            OP_SW:       ImmSrc = 2'b01;
            OP_BEQ:      ImmSrc = 2'b10;
            OP_JAL:      ImmSrc = 2'b11;
            default:     ImmSrc = 2'b00;
        endcase
    end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    assign Illegal = ~reset & ctl_q.illegal;
`else
    assign Illegal = 1'b0;
`endif

    assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: vector table, reset/trap sequences, random run.
module tb_multicycle_ctrl;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = LW;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;
    logic [3:0] dbg_state;

    always #5 clk = ~clk;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUOp(ALUOp), .RegWrite(RegWrite), .Illegal(Illegal),
        .dbg_state(dbg_state)
    );

    wire [19:0] act = {dbg_state, PCWrite, IRWrite, MemWrite, RegWrite,
                       AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
                       Illegal};

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst;
        logic       z;
        logic       mr;
        logic [6:0] op;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [19:0] pk(
        input logic [3:0] st, input logic [4:0] strb,
        input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sb,
        input logic [1:0] aop, input logic [1:0] imm, input logic ill);
        return {st, strb, res, sa, sb, aop, imm, ill};
    endfunction

    // in = {rst, Zero, MemReady}; strb = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc}
    function automatic vec_t mk(
        input logic [2:0] in, input logic [6:0] o, input logic [3:0] st,
        input logic [4:0] strb, input logic [1:0] res, input logic [1:0] sa,
        input logic [1:0] sb, input logic [1:0] aop, input logic [1:0] imm);
        vec_t v;
        v.rst = in[2];
        v.z   = in[1];
        v.mr  = in[0];
        v.op  = o;
        v.exp = pk(st, strb, res, sa, sb, aop, imm, 1'b0);
        return v;
    endfunction

    // Reference: per-state control values, plus the op/Zero/MemReady rules.
    logic [1:0] m_res [0:11] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00,
                                 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] m_sa  [0:11] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00,
                                 2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00};
    logic [1:0] m_sb  [0:11] = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00,
                                 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
    logic [1:0] m_aop [0:11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == LW || o == IT) return 2'b00;
        if (o == SW)  return 2'b01;
        if (o == BEQ) return 2'b10;
        if (o == JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [19:0] model(input int st, input logic [6:0] o,
                                          input logic z, input logic mr);
        logic pcw, irw, mw, rw, adr;
        pcw = (st == 0 && mr) || st == 10 || (st == 9 && z);
        irw = (st == 0 && mr);
        mw  = (st == 5);
        rw  = (st == 4 || st == 8);
        adr = (st == 3 || st == 5);
        return pk(4'(st), {pcw, irw, mw, rw, adr}, m_res[st], m_sa[st],
                  m_sb[st], m_aop[st], imm_of(o), st == 11);
    endfunction

    task automatic cyc(input logic r, input logic [6:0] o, input logic z,
                       input logic m);
        @(negedge clk);
        reset = r;
        op = o;
        Zero = z;
        MemReady = m;
        #1;
    endtask

    task automatic chk(input string name, input logic [19:0] a,
                       input logic [19:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic chk1(input string name, input logic [3:0] a,
                        input logic [3:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    initial begin
        int path[$];
        logic [6:0] o;
        logic z, mr;
        int stalls, k;

        tbl.push_back(mk(3'b101, LW, 4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00));
        tbl.push_back(mk(3'b101, LW, 4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00));
        tbl.push_back(mk(3'b001, LW, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00));
        tbl.push_back(mk(3'b001, LW, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(3'b001, LW, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(3'b000, LW, 4'd3, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(3'b000, LW, 4'd3, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(3'b000, LW, 4'd3, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(3'b001, LW, 4'd3, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(3'b001, LW, 4'd4, 5'b00010, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(3'b001, SW, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01));
        tbl.push_back(mk(3'b001, SW, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01));
        tbl.push_back(mk(3'b001, SW, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01));
        tbl.push_back(mk(3'b000, SW, 4'd5, 5'b00101, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
        tbl.push_back(mk(3'b000, SW, 4'd5, 5'b00101, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
        tbl.push_back(mk(3'b001, SW, 4'd5, 5'b00101, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
        tbl.push_back(mk(3'b001, BEQ, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10));
        tbl.push_back(mk(3'b001, BEQ, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10));
        tbl.push_back(mk(3'b011, BEQ, 4'd9, 5'b10000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10));
        tbl.push_back(mk(3'b001, BEQ, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10));
        tbl.push_back(mk(3'b001, BEQ, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10));
        tbl.push_back(mk(3'b001, BEQ, 4'd9, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10));
        tbl.push_back(mk(3'b001, JAL, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11));
        tbl.push_back(mk(3'b001, JAL, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11));
        tbl.push_back(mk(3'b001, JAL, 4'd10, 5'b10000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11));
        tbl.push_back(mk(3'b001, JAL, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11));
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        tbl.push_back(mk(3'b001, BAD, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00));
        tbl.push_back(mk(3'b001, BAD, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(3'b001, BAD, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00));
`endif

        cyc(1'b1, LW, 1'b0, 1'b1);
        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].mr);
            chk($sformatf("tbl[%0d]", i), act, tbl[i].exp);
        end

        // Reset asserted in the middle of a store stall.
        cyc(1'b1, SW, 1'b0, 1'b1);
        cyc(1'b0, SW, 1'b0, 1'b1);
        cyc(1'b0, SW, 1'b0, 1'b1);
        cyc(1'b0, SW, 1'b0, 1'b1);
        cyc(1'b0, SW, 1'b0, 1'b0);
        chk1("stall_state", dbg_state, 4'd5);
        cyc(1'b1, SW, 1'b0, 1'b0);
        chk1("rst_strobes", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
        chk1("rst_sel", {AdrSrc, 1'b0, ALUSrcB}, 4'b0010);
        cyc(1'b1, SW, 1'b0, 1'b0);
        chk1("rst_state", dbg_state, 4'd0);
        cyc(1'b0, SW, 1'b0, 1'b0);
        chk1("fetch_stall", {dbg_state[2:0], IRWrite}, 4'b0000);
        cyc(1'b0, SW, 1'b0, 1'b1);
        chk1("fetch_go", {dbg_state[2:0], IRWrite}, 4'b0001);
        cyc(1'b0, SW, 1'b0, 1'b1);
        chk1("decode_after", dbg_state, 4'd1);

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        cyc(1'b1, BAD, 1'b0, 1'b1);
        cyc(1'b0, BAD, 1'b0, 1'b1);
        cyc(1'b0, BAD, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, BAD, 1'b1, 1'b1);
            chk($sformatf("trap[%0d]", i), act, model(11, BAD, 1'b1, 1'b1));
        end
        cyc(1'b1, BAD, 1'b0, 1'b1);
        chk1("trap_rst_ill", {3'b000, Illegal}, 4'b0000);
        cyc(1'b0, BAD, 1'b0, 1'b1);
        chk1("trap_exit", {dbg_state[2:0], Illegal}, 4'b0000);
`endif

        cyc(1'b1, LW, 1'b0, 1'b1);
        for (int n = 0; n < 200; n++) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            k = $urandom_range(0, 5);
`else
            k = $urandom_range(0, 6);
`endif
            case (k)
                0: begin o = LW;  path = '{0, 1, 2, 3, 4}; end
                1: begin o = SW;  path = '{0, 1, 2, 5}; end
                2: begin o = RT;  path = '{0, 1, 6, 8}; end
                3: begin o = IT;  path = '{0, 1, 7, 8}; end
                4: begin o = BEQ; path = '{0, 1, 9}; end
                5: begin o = JAL; path = '{0, 1, 10, 8}; end
                default: begin
                    o = 7'($urandom);
                    while (o == LW || o == SW || o == RT || o == IT ||
                           o == BEQ || o == JAL)
                        o = 7'($urandom);
                    path = '{0, 1};
                end
            endcase
            foreach (path[j]) begin
                stalls = 0;
                while (1) begin
                    mr = (stalls >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    z = 1'($urandom);
                    cyc(1'b0, o, z, mr);
                    chk($sformatf("rand[%0d] st%0d", n, path[j]), act,
                        model(path[j], o, z, mr));
                    if ((path[j] == 0 || path[j] == 3 || path[j] == 5) && !mr)
                        stalls++;
                    else
                        break;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
